// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: FSM encoding, access-size
// constants and the address range check.
package mem_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t LD_RD   = 3'd1;
    localparam state_t LD_CAP  = 3'd2;
    localparam state_t RMW_RD  = 3'd3;
    localparam state_t RMW_MRG = 3'd4;
    localparam state_t ST_WR   = 3'd5;
    localparam state_t RESP    = 3'd6;

    localparam logic BYTE = 1'b0;
    localparam logic WORD = 1'b1;

    // A word access touches addr and addr+1; both must be implemented bytes.
    function automatic logic addr_in_range(input logic [31:0] addr, input logic word,
                                           input int unsigned mem_bytes);
        if (word == WORD) begin
            return (addr + 32'd1) < mem_bytes;
        end
        return addr < mem_bytes;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extender: passes a 16-bit word through or zero/sign
// extends the low byte. Shared with the writeback stage.
module load_extend
    import mem_pkg::*;
(
    input  logic [15:0] raw,
    input  logic        word,
    input  logic        sign_ext,
    output logic [15:0] data
);

    always_comb begin
        if (word == WORD) begin
            data = raw;
        end else if (sign_ext) begin
            data = {{8{raw[7]}}, raw[7:0]};
        end else begin
            data = {8'h00, raw[7:0]};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the data-memory port: one load/store at a time,
// byte stores done as read-modify-write because the memory always writes two bytes.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MEM_BYTES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_word,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [15:0]           resp_data,
    output logic                  resp_err,
    output logic                  mem_wr_enable,
    output logic                  mem_rd_enable,
    output logic [15:0]           mem_addr_bus,
    output logic [15:0]           mem_in_bus,
    output logic                  mem_number_of_byte,
    input  logic [15:0]           mem_out_bus
);

    state_t                  state_q, state_d;
    logic                    write_q, write_d;
    logic                    word_q, word_d;
    logic                    signed_q, signed_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [15:0]             resp_data_q, resp_data_d;
    logic                    resp_err_q, resp_err_d;
    logic [15:0]             ext_data;
    logic                    req_in_range;

    load_extend u_load_extend (
        .raw      (mem_out_bus),
        .word     (word_q),
        .sign_ext (signed_q),
        .data     (ext_data)
    );

    assign req_in_range = addr_in_range(32'(req_addr), req_word, MEM_BYTES);

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        word_d      = word_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d     = req_write;
                    word_d      = req_word;
                    signed_d    = req_signed;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    resp_data_d = 16'h0000;
                    if (!req_in_range) begin
                        resp_err_d = 1'b1;
                        state_d    = RESP;
                    end else if (!req_write) begin
                        state_d = LD_RD;
                    end else if (req_word == WORD) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LD_RD:   state_d = LD_CAP;
            LD_CAP: begin
                resp_data_d = ext_data;
                state_d     = RESP;
            end
            RMW_RD:  state_d = RMW_MRG;
            RMW_MRG: begin
                // Keep the neighbouring byte as read, replace only the addressed one.
                wdata_d = {mem_out_bus[15:8], wdata_q[7:0]};
                state_d = ST_WR;
            end
            ST_WR: begin
                resp_data_d = 16'h0000;
                state_d     = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_err_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            word_q      <= 1'b0;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 16'h0000;
            resp_data_q <= 16'h0000;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            word_q      <= word_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Memory-side outputs come only from registered state and latched request fields.
    always_comb begin
        req_ready          = (state_q == IDLE);
        resp_valid         = (state_q == RESP);
        resp_data          = resp_data_q;
        resp_err           = resp_err_q;
        mem_rd_enable      = (state_q == LD_RD) || (state_q == RMW_RD);
        mem_wr_enable      = (state_q == ST_WR);
        mem_addr_bus       = 16'(addr_q);
        mem_in_bus         = (state_q == ST_WR) ? wdata_q : 16'h0000;
        mem_number_of_byte = BYTE;
        case (state_q)
            LD_RD:         mem_number_of_byte = word_q;
            RMW_RD, ST_WR: mem_number_of_byte = WORD;
            default:       mem_number_of_byte = BYTE;
        endcase
    end

    logic unused_write;
    assign unused_write = write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural byte memory, directed vector table,
// hand-written backpressure / reset sequences and randomized traffic vs a byte-array model.
module tb_mem_access_unit;

    localparam int MEMB = 1024;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_word;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        resp_err;
    logic        mem_wr_enable;
    logic        mem_rd_enable;
    logic [15:0] mem_addr_bus;
    logic [15:0] mem_in_bus;
    logic        mem_number_of_byte;
    logic [15:0] mem_out_bus;

    mem_access_unit #(
        .ADDR_WIDTH (16),
        .MEM_BYTES  (MEMB)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_word           (req_word),
        .req_signed         (req_signed),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_data          (resp_data),
        .resp_err           (resp_err),
        .mem_wr_enable      (mem_wr_enable),
        .mem_rd_enable      (mem_rd_enable),
        .mem_addr_bus       (mem_addr_bus),
        .mem_in_bus         (mem_in_bus),
        .mem_number_of_byte (mem_number_of_byte),
        .mem_out_bus        (mem_out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: registered read data; byte mode still drives the next byte on [15:8].
    bit [7:0] mem [0:MEMB-1];
    bit [7:0] ref_mem [0:MEMB-1];

    function automatic bit [7:0] mb(input int a);
        return (a < MEMB) ? mem[a] : 8'h00;
    endfunction

    function automatic bit [7:0] rb(input int a);
        return (a < MEMB) ? ref_mem[a] : 8'h00;
    endfunction

    initial mem_out_bus = 16'h0000;
    always @(posedge clk) begin
        if (mem_rd_enable) begin
            mem_out_bus <= {mb(int'(mem_addr_bus) + 1), mb(int'(mem_addr_bus))};
        end
        if (mem_wr_enable) begin
            if (int'(mem_addr_bus) < MEMB) mem[int'(mem_addr_bus)] <= mem_in_bus[7:0];
            if (mem_number_of_byte && int'(mem_addr_bus) + 1 < MEMB)
                mem[int'(mem_addr_bus) + 1] <= mem_in_bus[15:8];
        end
    end

    // Bus trace, sampled mid-cycle.
    int          cyc = 0, rd_cnt = 0, wr_cnt = 0, last_rd_cyc = 0, last_wr_cyc = 0;
    logic [15:0] last_wr_data = 16'h0, last_wr_addr = 16'h0;
    logic        overlap = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_enable) begin
            rd_cnt      <= rd_cnt + 1;
            last_rd_cyc <= cyc;
        end
        if (mem_wr_enable) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_cyc  <= cyc;
            last_wr_data <= mem_in_bus;
            last_wr_addr <= mem_addr_bus;
        end
        if (mem_rd_enable && mem_wr_enable) overlap <= 1'b1;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        w;
        logic        wd;
        logic        s;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        logic [15:0] exp_win;
    } txn_t;

    // Reference model: byte-addressed array, rules straight from the access semantics.
    task automatic predict(input logic w, input logic wd, input logic s,
                           input logic [15:0] a, input logic [15:0] d, output txn_t t);
        int              ai;
        logic [7:0]      b;
        logic signed [15:0] sx;
        ai = int'(a);
        t.w = w; t.wd = wd; t.s = s; t.a = a; t.d = d;
        t.exp_data = 16'h0;
        t.exp_win  = 16'h0;
        t.exp_err  = wd ? (ai + 1 >= MEMB) : (ai >= MEMB);
        if (t.exp_err) begin
            t.exp_lat = 1;
        end else if (!w) begin
            t.exp_lat = 3;
            b = rb(ai);
            sx = $signed(b);
            if (wd) t.exp_data = {rb(ai + 1), b};
            else if (s) t.exp_data = sx;
            else t.exp_data = {8'h00, b};
        end else if (wd) begin
            t.exp_lat = 2;
            t.exp_win = d;
            ref_mem[ai]     = d[7:0];
            ref_mem[ai + 1] = d[15:8];
        end else begin
            t.exp_lat = 4;
            t.exp_win = {rb(ai + 1), d[7:0]};
            ref_mem[ai] = d[7:0];
        end
    endtask

    task automatic scramble_req();
        req_valid  = 1'($urandom);
        req_write  = 1'($urandom);
        req_word   = 1'($urandom);
        req_signed = 1'($urandom);
        req_addr   = 16'($urandom);
        req_wdata  = 16'($urandom);
    endtask

    // Issue one request from IDLE; returns response and edges from accept to resp_valid.
    task automatic issue(input txn_t t, output logic [15:0] data, output logic err,
                         output int lat);
        chk("ready before request", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = t.w;
        req_word   = t.wd;
        req_signed = t.s;
        req_addr   = t.a;
        req_wdata  = t.d;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        scramble_req();
        while (!resp_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
            scramble_req();
        end
        req_valid = 1'b0;
        if (!resp_valid) chk("resp_valid timeout", 32'(resp_valid), 32'd1);
        data = resp_data;
        err  = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic check_txn(input txn_t t, input string tag);
        logic [15:0] d;
        logic        e;
        int          lat, rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        issue(t, d, e, lat);
        chk({tag, " data"}, 32'(d), 32'(t.exp_data));
        chk({tag, " err"}, 32'(e), 32'(t.exp_err));
        chk({tag, " latency"}, 32'(lat), 32'(t.exp_lat));
        chk({tag, " rd pulses"}, 32'(rd_cnt - rd0),
            (!t.exp_err && !(t.w && t.wd)) ? 32'd1 : 32'd0);
        chk({tag, " wr pulses"}, 32'(wr_cnt - wr0), (!t.exp_err && t.w) ? 32'd1 : 32'd0);
        if (t.w && !t.exp_err) begin
            chk({tag, " wr data"}, 32'(last_wr_data), 32'(t.exp_win));
            chk({tag, " wr addr"}, 32'(last_wr_addr), 32'(t.a));
            if (!t.wd) chk({tag, " rd-to-wr gap"}, 32'(last_wr_cyc - last_rd_cyc), 32'd2);
        end
    endtask

    localparam int NT = 18;
    txn_t tbl [NT];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t        p;
        logic [15:0] bp_data;
        int          wr_before, bp_lat;

        //            w     wd    s     addr      wdata     data      err   lat win
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 2, 16'hBEEF};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 3, 16'h0000};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'h8000, 16'h0000, 1'b0, 2, 16'h8000};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 16'h0022, 16'h0077, 16'h0000, 1'b0, 2, 16'h0077};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h0021, 16'h0000, 16'hFF80, 1'b0, 3, 16'h0000};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000, 16'h0080, 1'b0, 3, 16'h0000};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'h0030, 16'h1234, 16'h0000, 1'b0, 2, 16'h1234};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0030, 16'h00AB, 16'h0000, 1'b0, 4, 16'h12AB};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h12AB, 1'b0, 3, 16'h0000};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0031, 16'h0000, 16'h0012, 1'b0, 3, 16'h0000};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 16'h03FE, 16'h5AC3, 16'h0000, 1'b0, 2, 16'h5AC3};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h03FF, 16'h0000, 16'h0000, 1'b1, 1, 16'h0000};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 16'h03FF, 16'h0000, 16'h005A, 1'b0, 3, 16'h0000};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 16'h03FE, 16'h0000, 16'h5AC3, 1'b0, 3, 16'h0000};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 16'h03FE, 16'h0000, 16'hFFC3, 1'b0, 3, 16'h0000};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 16'h0400, 16'h0011, 16'h0000, 1'b1, 1, 16'h0000};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 16'h03FF, 16'h2222, 16'h0000, 1'b1, 1, 16'h0000};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1, 16'h0000};

        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0; req_signed = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0; resp_ready = 1'b0;
        #12;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid/err", {30'd0, resp_valid, resp_err}, 32'd0);
        chk("reset enables", {30'd0, mem_rd_enable, mem_wr_enable}, 32'd0);
        chk("reset resp_data", 32'(resp_data), 32'd0);
        chk("reset mem buses", {mem_addr_bus, mem_in_bus}, 32'd0);
        chk("reset number_of_byte", 32'(mem_number_of_byte), 32'd0);

        for (int i = 0; i < NT; i++) begin
            predict(tbl[i].w, tbl[i].wd, tbl[i].s, tbl[i].a, tbl[i].d, p);
            check_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Backpressure: response held for 5 cycles; request fields wiggle while busy.
        req_valid = 1'b1; req_write = 1'b0; req_word = 1'b1; req_signed = 1'b0;
        req_addr = 16'h0010; req_wdata = 16'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = 16'h0030;
        bp_lat = 1;
        while (!resp_valid && bp_lat < 16) begin
            @(posedge clk); #1;
            bp_lat++;
            req_addr = 16'($urandom);
        end
        chk("bp latency", 32'(bp_lat), 32'd3);
        bp_data = resp_data;
        chk("bp data", 32'(bp_data), 32'hBEEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d valid/ready", i), {30'd0, resp_valid, req_ready},
                32'd2);
            chk($sformatf("bp hold%0d data", i), 32'(resp_data), 32'hBEEF);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp released valid/ready", {30'd0, resp_valid, req_ready}, 32'd1);

        // Reset while a byte store sits between its read and its write.
        predict(1'b1, 1'b1, 1'b0, 16'h0040, 16'h7766, p);
        check_txn(p, "rst preset");
        wr_before = wr_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_word = 1'b0; req_signed = 1'b0;
        req_addr = 16'h0040; req_wdata = 16'h00EE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst rmw read issued", 32'(mem_rd_enable), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst enables drop", {30'd0, mem_rd_enable, mem_wr_enable}, 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst mem_addr_bus", 32'(mem_addr_bus), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst after release ready", 32'(req_ready), 32'd1);
        chk("rst no write", 32'(wr_cnt - wr_before), 32'd0);
        predict(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, p);
        check_txn(p, "rst reload");

        for (int i = 0; i < 150; i++) begin
            logic [15:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 16'(1019 + $urandom_range(0, 7))
                                             : 16'($urandom_range(0, 127));
            predict(1'($urandom), 1'($urandom), 1'($urandom), ra, 16'($urandom), p);
            check_txn(p, $sformatf("rand%0d", i));
        end

        chk("rd/wr never together", 32'(overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port; sits in the pipeline MEM stage.
- Accepts one load/store request at a time from the pipeline over a valid/ready handshake and drives the data-memory enables, address, write data and byte-count select.
- Returns load data with zero- or sign-extension. Byte stores use read-modify-write, because the memory always writes two bytes per write.
- Stalls the pipeline through `req_ready` while an access is in flight.

Parameters:
- `ADDR_WIDTH`, 16, byte-address width.
- `MEM_BYTES`, 1024, number of implemented memory bytes; sets the range check.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  pipeline request present.
- `req_ready`  out  1  unit idle, request accepted this edge.
- `req_write`  in  1  1 = store, 0 = load.
- `req_word`  in  1  1 = 16-bit, 0 = 8-bit.
- `req_signed`  in  1  byte load sign-extends when 1; ignored otherwise.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  16  store data; byte store uses [7:0].
- `resp_valid`  out  1  access complete.
- `resp_ready`  in  1  pipeline consumes response.
- `resp_data`  out  16  load result; 0 for stores.
- `resp_err`  out  1  address out of range, no memory access made.
- `mem_wr_enable`  out  1  to memory write enable.
- `mem_rd_enable`  out  1  to memory read enable.
- `mem_addr_bus`  out  16  to memory address.
- `mem_in_bus`  out  16  to memory write data.
- `mem_number_of_byte`  out  1  1 = two bytes, 0 = one byte.
- `mem_out_bus`  in  16  memory read data, registered by memory on the edge it samples `mem_rd_enable`.

Behaviour:
- Reset (asynchronous, immediate, including mid-access):
  - State returns to IDLE.
  - `req_ready` = 1; `resp_valid`, `resp_err`, `mem_wr_enable`, `mem_rd_enable` = 0.
  - `resp_data`, `mem_addr_bus`, `mem_in_bus` = 0; `mem_number_of_byte` = 0.
  - A partially completed read-modify-write is abandoned; the memory is left unwritten.
- Output drive rules:
  - All `mem_*` outputs are decoded from registered state and latched request registers only.
  - There is no combinational path from `req_*` to `mem_*`.
  - `mem_wr_enable` and `mem_rd_enable` are never high in the same cycle.
- State IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch write, word, signed, addr and wdata.
  - Range check, in priority order:
    - Word access with addr + 1 >= MEM_BYTES, or byte access with addr >= MEM_BYTES → RESP, `resp_err` = 1, `resp_data` = 0.
    - Otherwise load → LD_RD; word store → ST_WR; byte store → RMW_RD.
- State LD_RD (1 cycle): `mem_rd_enable` = 1; `mem_number_of_byte` = latched word flag; next LD_CAP.
- State LD_CAP (1 cycle): enables low. At the edge, `resp_data` is loaded with:
  - word: `mem_out_bus`;
  - byte unsigned: {8'h00, `mem_out_bus`[7:0]};
  - byte signed: {8{`mem_out_bus`[7]}, `mem_out_bus`[7:0]}.
  - Next RESP.
- State RMW_RD (1 cycle): `mem_rd_enable` = 1, `mem_number_of_byte` = 1; next RMW_MRG.
- State RMW_MRG (1 cycle): latch merge = {`mem_out_bus`[15:8], wdata[7:0]} into the write-data register; next ST_WR.
- State ST_WR (1 cycle): `mem_wr_enable` = 1; `mem_in_bus` = write-data register; next RESP with `resp_data` = 0.
- State RESP:
  - `resp_valid` = 1; `resp_data` and `resp_err` held stable.
  - When `resp_ready` = 1, go to IDLE at the edge and clear `resp_valid`/`resp_err` the same edge.
  - The next request cannot be accepted in the same edge.
- Latency, counted in rising edges from the accepting edge to `resp_valid` high:
  - word store 2, load 3, byte store 4, range error 1.
  - `resp_ready` held high gives throughput of one access per latency+1 cycles.
- Busy: `req_ready` = 0 in every state except IDLE. `req_*` changes while busy are ignored; the latched copy is used.
- Address arithmetic: no wrap. Out-of-range accesses are reported, never issued.

Decomposition:
- Shared package `mem_pkg`:
  - state enum (IDLE, LD_RD, LD_CAP, RMW_RD, RMW_MRG, ST_WR, RESP);
  - constants BYTE = 1'b0, WORD = 1'b1.
- Natural sub-module: `load_extend`, a combinational 16-bit zero/sign extender selected by word/signed. It is reused by the writeback stage.

Test Plan:
- Word store then load: store addr 0x0010 data 0xBEEF, then load word 0x0010 → `resp_data` = 0xBEEF; load latency 3 edges; exactly one `mem_wr_enable` pulse seen.
- Signed and unsigned byte loads: memory holds 0x80 at addr 0x0021. Byte load signed → 0xFF80; byte load unsigned → 0x0080.
- Byte-store read-modify-write: memory holds 0x1234 at addr 0x0030, byte store 0x00AB to 0x0030 → memory reads 0x12AB; addr 0x0031 is unchanged (0x12). Trace shows rd pulse, then wr pulse two cycles later, with `mem_in_bus` = 0x12AB.
- Range boundary:
  - word load addr 1023 → `resp_err` = 1, no `mem_*` enable pulse;
  - byte load addr 1023 → `resp_err` = 0 with data returned;
  - word load addr 1022 → OK.
- Backpressure and busy: hold `resp_ready` = 0 for 5 cycles → `resp_valid` and `resp_data` stable, `req_ready` = 0. Toggle `req_addr` mid-access → result unaffected.
- Reset mid-access: assert `rst_n` = 0 during RMW_MRG → enables drop immediately, target byte unwritten, `req_ready` = 1 after release. A subsequent load works.
